if_id_stage: RTL and testbench

//   Fetch stage plus IF/ID pipeline register for the 5-stage pipelined RV32I core.

---
 rtl/if_id_stage.sv | 96 +++++++++
 tb/tb_if_id_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC generation, instruction latch,
// hazard stall hold, and flush redirect with a bubble into decode.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_plus4,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  id_pc_q, id_pc_d;
    logic [XLEN-1:0]  id_pc_plus4_q, id_pc_plus4_d;
    logic [XLEN-1:0]  id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  pc_plus4;

    // Modulo-2^32 adder: the top word wraps to zero silently.
    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state: flush beats stall, stall holds everything, else advance.
    always_comb begin
        pc_d          = pc_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_valid_d    = id_valid_q;
        misalign_d    = misalign_q;
        flush_cnt_d   = flush_cnt_q;

        if (flush) begin
            pc_d          = {branch_target[XLEN-1:2], 2'b00};
            id_pc_d       = '0;
            id_pc_plus4_d = '0;
            id_instr_d    = NOP_INSTR;
            id_valid_d    = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (!stall) begin
            pc_d          = pc_plus4;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_instr_d    = imem_rdata;
            id_valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_instr_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            flush_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus4  = id_pc_plus4_q;
    assign id_instr     = id_instr_q;
    assign id_valid     = id_valid_q;
    assign misalign_err = misalign_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a default instance plus a CNT_W=2 instance
// sharing stimulus so counter saturation can be observed.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] id_pc, id_pc_plus4, id_instr;
    logic        id_valid, misalign_err;
    logic [15:0] flush_count;

    logic [31:0] s_imem_addr, s_imem_rdata;
    logic [31:0] s_id_pc, s_id_pc_plus4, s_id_instr;
    logic        s_id_valid, s_misalign_err;
    logic [1:0]  s_flush_count;

    int n_chk;
    int n_fail;

    // Instruction memory model: two fixed words, otherwise address-tagged addi-like word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h0050_0093;
            32'h4:   mem = 32'h00A0_0113;
            default: mem = {a[23:0], 8'h13};
        endcase
    endfunction

    assign imem_rdata   = mem(imem_addr);
    assign s_imem_rdata = mem(s_imem_addr);

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr), .id_valid(id_valid),
        .misalign_err(misalign_err), .flush_count(flush_count)
    );

    if_id_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_addr(s_imem_addr),
        .imem_rdata(s_imem_rdata), .id_pc(s_id_pc), .id_pc_plus4(s_id_pc_plus4),
        .id_instr(s_id_instr), .id_valid(s_id_valid),
        .misalign_err(s_misalign_err), .flush_count(s_flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        branch_target = '0;
        #12;
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_id_pc",  id_pc, 32'h0);
        check("rst_plus4",  id_pc_plus4, 32'h0);
        check("rst_instr",  id_instr, 32'h13);
        check("rst_valid",  32'(id_valid), 32'h0);
        check("rst_mis",    32'(misalign_err), 32'h0);
        check("rst_cnt",    32'(flush_count), 32'h0);
        rst_n = 1'b1;

        // Straight-line fetch.
        step();
        check("c1_pc",    id_pc, 32'h0);
        check("c1_instr", id_instr, 32'h0050_0093);
        check("c1_valid", 32'(id_valid), 32'h1);
        check("c1_plus4", id_pc_plus4, 32'h4);
        check("c1_addr",  imem_addr, 32'h4);
        step();
        check("c2_pc",    id_pc, 32'h4);
        check("c2_instr", id_instr, 32'h00A0_0113);
        step();
        check("c3_pc",    id_pc, 32'h8);

        // Stall holds for three cycles.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc",    id_pc, 32'h8);
            check("stall_instr", id_instr, 32'h0000_0813);
            check("stall_addr",  imem_addr, 32'hC);
        end
        stall = 1'b0;
        step();
        check("unstall_pc",    id_pc, 32'hC);
        check("unstall_instr", id_instr, 32'h0000_0C13);
        check("unstall_addr",  imem_addr, 32'h10);

        // Flush to 0x40 at pc_q=16.
        flush = 1'b1;
        branch_target = 32'h40;
        step();
        check("fl_addr",  imem_addr, 32'h40);
        check("fl_instr", id_instr, 32'h13);
        check("fl_valid", 32'(id_valid), 32'h0);
        check("fl_pc",    id_pc, 32'h0);
        check("fl_cnt",   32'(flush_count), 32'h1);
        check("fl_cnt2",  32'(s_flush_count), 32'h1);
        flush = 1'b0;
        step();
        check("fl_next_pc",    id_pc, 32'h40);
        check("fl_next_valid", 32'(id_valid), 32'h1);
        check("fl_next_instr", id_instr, 32'h0000_4013);

        // Flush and stall together: flush wins.
        flush = 1'b1;
        stall = 1'b1;
        branch_target = 32'h80;
        step();
        check("fs_addr",  imem_addr, 32'h80);
        check("fs_valid", 32'(id_valid), 32'h0);
        check("fs_instr", id_instr, 32'h13);
        flush = 1'b0;
        stall = 1'b0;
        step();
        check("fs_next_pc", id_pc, 32'h80);

        // Misaligned target: aligned PC, sticky error.
        flush = 1'b1;
        branch_target = 32'h42;
        step();
        check("mis_addr", imem_addr, 32'h40);
        check("mis_err",  32'(misalign_err), 32'h1);
        check("mis_cnt",  32'(flush_count), 32'h3);
        check("mis_cnt2", 32'(s_flush_count), 32'h3);
        flush = 1'b0;
        step();
        step();
        check("mis_sticky", 32'(misalign_err), 32'h1);

        // Flush held two cycles: two bubbles, then fetch from target.
        flush = 1'b1;
        branch_target = 32'h100;
        step();
        step();
        check("hold_addr",  imem_addr, 32'h100);
        check("hold_valid", 32'(id_valid), 32'h0);
        check("hold_cnt",   32'(flush_count), 32'h5);
        check("sat_cnt",    32'(s_flush_count), 32'h3);
        flush = 1'b0;
        step();
        check("hold_next_pc", id_pc, 32'h100);

        // PC wrap at the top of the address space.
        flush = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4, 32'h0);
        check("wrap_addr",  imem_addr, 32'h0);
        step();
        check("wrap_fetch", id_instr, 32'h0050_0093);

        // Asynchronous reset in the middle of a stall.
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr",  imem_addr, 32'h0);
        check("arst_pc",    id_pc, 32'h0);
        check("arst_instr", id_instr, 32'h13);
        check("arst_valid", 32'(id_valid), 32'h0);
        check("arst_mis",   32'(misalign_err), 32'h0);
        check("arst_cnt",   32'(flush_count), 32'h0);
        check("arst_cnt2",  32'(s_flush_count), 32'h0);
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        step();
        check("post_rst_pc",    id_pc, 32'h0);
        check("post_rst_instr", id_instr, 32'h0050_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
